eth_ram_writer: RTL and testbench

ETH_RAM_WRITER -- requirements
Module: eth_ram_writer

---
 rtl/eth_ram_writer_pkg.sv | 13 +
 rtl/eth_byte_packer.sv | 47 ++++
 rtl/eth_ram_writer.sv | 105 ++++++++++
 tb/tb_eth_ram_writer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_ram_writer_pkg.sv
// Shared definitions for the Ethernet receive-to-RAM writer.
package eth_ram_writer_pkg;
  localparam int ADDR_W_DEF     = 13;
  localparam int DATA_W_DEF     = 16;
  localparam int BANK_WORDS_DEF = 4096;
  localparam int DROP_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FILL      = 2'd1,
    ST_WAIT_BANK = 2'd2
  } wr_state_e;
endpackage

// File: rtl/eth_byte_packer.sv
// Packs accepted bytes big-endian into 16-bit words; a packet ending on a
// high byte is padded with 8'h00 in the low byte.
module eth_byte_packer (
  input  logic        wr_clk,
  input  logic        tb_wr_rst,
  input  logic        acc_i,
  input  logic [7:0]  data_i,
  input  logic        last_i,
  output logic        word_vld_o,
  output logic [15:0] word_o
);
  logic       hi_phase_q, hi_phase_d;  // 1: next accepted byte is the high byte
  logic [7:0] hi_q, hi_d;

  // Byte-phase tracking and word assembly
  always_comb begin
    hi_phase_d = hi_phase_q;
    hi_d       = hi_q;
    word_vld_o = 1'b0;
    word_o     = {hi_q, data_i};
    if (acc_i) begin
      if (hi_phase_q) begin
        if (last_i) begin
          word_vld_o = 1'b1;
          word_o     = {data_i, 8'h00};
        end else begin
          hi_d       = data_i;
          hi_phase_d = 1'b0;
        end
      end else begin
        word_vld_o = 1'b1;
        hi_phase_d = 1'b1;
      end
    end
  end

  // Pending high byte is held indefinitely while no byte is accepted
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      hi_phase_q <= 1'b1;
      hi_q       <= '0;
    end else begin
      hi_phase_q <= hi_phase_d;
      hi_q       <= hi_d;
    end
  end
endmodule

// File: rtl/eth_ram_writer.sv
// Writes the Ethernet byte stream into a ping-pong RAM, one bank per
// BANK_WORDS words; stalls the source when the next bank is still owned by
// the reader.
module eth_ram_writer
  import eth_ram_writer_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BANK_WORDS = BANK_WORDS_DEF
) (
  input  logic              wr_clk,
  input  logic              tb_wr_rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [1:0]        bank_release,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [1:0]        bank_full,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int WA_W = ADDR_W - 1;

  wr_state_e         state_q, state_d;
  logic              cur_q, cur_d;
  logic [WA_W-1:0]   waddr_q, waddr_d;
  logic [1:0]        full_q, full_d;
  logic [DROP_W-1:0] drop_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              bubble_q;   // cycle in which the bank's final word is on the RAM port
  logic              acc, word_vld, bank_end;
  logic [15:0]       word;

  assign s_ready = (state_q == ST_FILL) & ~bubble_q;
  assign acc     = s_valid & s_ready;

  eth_byte_packer u_packer (
    .wr_clk     (wr_clk),
    .tb_wr_rst  (tb_wr_rst),
    .acc_i      (acc),
    .data_i     (s_data),
    .last_i     (s_last),
    .word_vld_o (word_vld),
    .word_o     (word)
  );

  assign bank_end = word_vld && (waddr_q == WA_W'(BANK_WORDS - 1));

  // Bank bookkeeping and FSM next state; a set of bank_full beats a release
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    waddr_d = waddr_q;
    full_d  = full_q & ~bank_release;
    if (word_vld) waddr_d = waddr_q + 1'b1;
    if (bank_end) begin
      full_d[cur_q] = 1'b1;
      cur_d         = ~cur_q;
      waddr_d       = '0;
    end
    case (state_q)
      ST_IDLE:      state_d = ST_FILL;
      ST_FILL:      if (bank_end && full_d[~cur_q]) state_d = ST_WAIT_BANK;
      ST_WAIT_BANK: if (bank_release[cur_q]) state_d = ST_FILL;
      default:      state_d = ST_IDLE;
    endcase
  end

  // State, RAM port registers and the saturating drop counter
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      state_q  <= ST_IDLE;
      cur_q    <= 1'b0;
      waddr_q  <= '0;
      full_q   <= '0;
      drop_q   <= '0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      bubble_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      waddr_q  <= waddr_d;
      full_q   <= full_d;
      wen_q    <= word_vld;
      bubble_q <= bank_end;
      if (word_vld) begin
        addr_q <= {cur_q, waddr_q};
        data_q <= DATA_W'(word);
      end
      if (s_valid && !s_ready && !(&drop_q)) drop_q <= drop_q + 1'b1;
    end
  end

  assign ram_wr_en   = wen_q;
  assign ram_wr_addr = addr_q;
  assign ram_wr_data = data_q;
  assign bank_full   = full_q;
  assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_eth_ram_writer.sv
// Randomized and directed checks of eth_ram_writer against a transaction
// level model: a byte stream packed into words written to consecutive
// addresses of alternating banks.
module tb_eth_ram_writer;
  localparam int BW = 4096;

  logic        wr_clk = 1'b0;
  logic        tb_wr_rst;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_ready;
  logic [1:0]  bank_release;
  logic        ram_wr_en;
  logic [12:0] ram_wr_addr;
  logic [15:0] ram_wr_data;
  logic [1:0]  bank_full;
  logic [15:0] drop_cnt;

  eth_ram_writer dut (
    .wr_clk       (wr_clk),
    .tb_wr_rst    (tb_wr_rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .bank_release (bank_release),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data),
    .bank_full    (bank_full),
    .drop_cnt     (drop_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [15:0] q_data[$];
  logic [12:0] q_addr[$];
  int          m_widx;     // words produced since reset
  logic        m_hv;       // pending high byte present
  logic [7:0]  m_hi;
  logic [1:0]  m_full;
  logic [15:0] m_drop;
  logic        m_bubble, m_idle, m_acc;
  int          n_wr;
  logic [12:0] last_addr;
  logic [15:0] last_data;

  task automatic m_reset();
    q_data.delete(); q_addr.delete();
    m_widx = 0; m_hv = 0; m_hi = 0; m_full = 0; m_drop = 0;
    m_bubble = 0; m_idle = 1; m_acc = 0;
  endtask

  // Word k lands at k mod (2*BW); the last word of a bank marks it full
  task automatic push(input logic [15:0] w, inout logic [1:0] set_now, inout logic fin);
    q_data.push_back(w);
    q_addr.push_back(13'(m_widx % (2 * BW)));
    if (m_widx % BW == BW - 1) begin
      set_now[(m_widx / BW) % 2] = 1'b1;
      fin = 1'b1;
    end
    m_widx++;
  endtask

  // One clock: check outputs at negedge, advance model with this cycle's inputs
  task automatic tick();
    logic       e_rdy;
    logic [1:0] set_now;
    logic       fin;
    @(negedge wr_clk);
    if (ram_wr_en) begin
      n_wr++;
      last_addr = ram_wr_addr;
      last_data = ram_wr_data;
      if (q_data.size() == 0) chk("spurious_wr", 1, 0);
      else begin
        chk("wr_addr", ram_wr_addr, q_addr.pop_front());
        chk("wr_data", ram_wr_data, q_data.pop_front());
      end
    end
    e_rdy = !m_idle && !m_bubble && !m_full[(m_widx / BW) % 2];
    chk("s_ready", s_ready, e_rdy);
    chk("bank_full", bank_full, m_full);
    chk("drop_cnt", drop_cnt, m_drop);
    set_now = 0; fin = 0;
    m_acc = s_valid && e_rdy;
    if (s_valid && !e_rdy && m_drop != 16'hFFFF) m_drop++;
    if (m_acc) begin
      if (!m_hv) begin
        if (s_last) push({s_data, 8'h00}, set_now, fin);
        else begin m_hv = 1; m_hi = s_data; end
      end else begin
        push({m_hi, s_data}, set_now, fin);
        m_hv = 0;
      end
    end
    m_full   = set_now | (m_full & ~bank_release);
    m_bubble = fin;
    m_idle   = 0;
    @(posedge wr_clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    s_valid = 1; s_data = d; s_last = l;
    do begin tick(); n++; end while (!m_acc && n < 5000);
    if (!m_acc) chk("accept_timeout", 0, 1);
    s_valid = 0; s_last = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"},  s_ready, 0);
    chk({tag, "_wen"},  ram_wr_en, 0);
    chk({tag, "_addr"}, ram_wr_addr, 0);
    chk({tag, "_data"}, ram_wr_data, 0);
    chk({tag, "_full"}, bank_full, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
  endtask

  initial begin
    int          w0;
    logic [15:0] d0;
    tb_wr_rst = 1; s_valid = 0; s_data = 0; s_last = 0; bank_release = 0;
    n_wr = 0; last_addr = 0; last_data = 0;
    m_reset();
    #3 chk_zero("rst");
    #197;
    @(posedge wr_clk); #1 tb_wr_rst = 0;

    // First pair
    send_byte(8'h12, 0); send_byte(8'h34, 0); tick();
    chk("first_wr_cnt", n_wr, 1);
    chk("first_wr_addr", last_addr, 0);
    chk("first_wr_data", last_data, 16'h1234);

    // Fill bank 0 then bank 1 with a down-counting stream, no release
    for (int i = 0; i < 2 * BW - 2; i++) send_byte(8'hFF - 8'(i), 0);
    tick();
    chk("bank0_full", bank_full, 2'b01);
    chk("bank0_last_addr", last_addr, 13'd4095);
    for (int i = 0; i < 2 * BW; i++) send_byte(8'hFF - 8'(i), 0);
    tick(); tick();
    chk("both_full", bank_full, 2'b11);
    chk("wait_rdy", s_ready, 0);
    chk("bank1_last_addr", last_addr, 13'd8191);

    // Ten stalled valid cycles
    d0 = m_drop;
    s_valid = 1; s_data = 8'h5A;
    repeat (10) tick();
    s_valid = 0;
    chk("drop_plus10", drop_cnt, d0 + 16'd10);

    // Release bank 0: back to FILL
    bank_release = 2'b01; tick(); bank_release = 0;
    tick();
    chk("rel_full", bank_full, 2'b10);
    chk("rel_rdy", s_ready, 1);

    // Short packet with padded tail
    w0 = n_wr;
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 1); tick();
    chk("pkt_wr_cnt", n_wr - w0, 2);
    chk("pkt_tail_addr", last_addr, 13'd1);
    chk("pkt_tail_data", last_data, 16'hCC00);

    // Random traffic with random releases
    for (int c = 0; c < 12000; c++) begin
      s_valid = ($urandom_range(9) < 8);
      s_data  = 8'($urandom);
      s_last  = ($urandom_range(9) == 0);
      bank_release = {($urandom_range(63) == 0), ($urandom_range(63) == 0)};
      tick();
    end
    s_valid = 0; s_last = 0; bank_release = 0;
    tick();
    bank_release = 2'b11; tick(); bank_release = 0;
    tick();

    // Advance to word 100 of a bank, leave an odd byte pending, then reset
    while (m_widx % BW != 100 || m_hv) send_byte(8'($urandom), 0);
    send_byte(8'h77, 0);
    chk("sb_pre_rst", q_data.size(), 0);
    @(negedge wr_clk); #2 tb_wr_rst = 1;
    #1 chk_zero("rst_mid");
    m_reset();
    repeat (3) @(posedge wr_clk);
    #1 tb_wr_rst = 0;
    tick(); tick();
    chk("no_wr_after_rst", ram_wr_en, 0);
    w0 = n_wr;
    send_byte(8'h55, 0); send_byte(8'h66, 0); tick(); tick();
    chk("rst_wr_cnt", n_wr - w0, 1);
    chk("rst_wr_addr", last_addr, 0);
    chk("rst_wr_data", last_data, 16'h5566);
    chk("sb_drain", q_data.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
